// File: rtl/muldiv_hilo_unit.sv
// Execute-stage HI/LO unit: pipelined-latency multiply, radix-2 restoring divide,
// MTHI/MTLO writes, and a combinational stall for the pipeline.
module muldiv_hilo_unit #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] ALU_MTHI  = 6'h11;
  localparam logic [5:0] ALU_MTLO  = 6'h13;
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic [31:0] rem_q, quo_q, dvs_q;

  logic        is_mul, is_div, accept;
  logic [31:0] a_mag, b_mag;
  logic [63:0] ma, mb, prod;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff, rem_step, quo_step;
  logic        a_neg, b_neg;
  logic [31:0] q_fix, r_fix;

  assign is_mul = (op == ALU_MULT) || (op == ALU_MULTU);
  assign is_div = (op == ALU_DIV)  || (op == ALU_DIVU);
  assign accept = (state_q == IDLE) && start && !flush && (is_mul || is_div);
  assign busy   = !rst && (accept || (state_q != IDLE));
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

  // Operand magnitudes for the divider; signed-ness only matters for DIV.
  assign a_mag = ((op == ALU_DIV) && src_a[31]) ? (32'd0 - src_a) : src_a;
  assign b_mag = ((op == ALU_DIV) && src_b[31]) ? (32'd0 - src_b) : src_b;

  assign a_neg = sgn_q & a_q[31];
  assign b_neg = sgn_q & b_q[31];

  assign ma   = {{32{a_neg}}, a_q};
  assign mb   = {{32{b_neg}}, b_q};
  assign prod = ma * mb;

  // Restoring step: remainder stays below the divisor, so a 32-bit difference suffices.
  assign shifted  = {rem_q, quo_q[31]};
  assign ge       = shifted >= {1'b0, dvs_q};
  assign diff     = shifted[31:0] - dvs_q;
  assign rem_step = ge ? diff : shifted[31:0];
  assign quo_step = {quo_q[30:0], ge};

  assign q_fix = (a_neg ^ b_neg) ? (32'd0 - quo_q) : quo_q;
  assign r_fix = a_neg ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_d = is_mul ? MUL : DIV;
        MUL:  if (cnt_q == '0) state_d = IDLE;
        DIV:  if (cnt_q == '0) state_d = FIX;
        FIX:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q   <= src_a;
            b_q   <= src_b;
            sgn_q <= (op == ALU_MULT) || (op == ALU_DIV);
            cnt_q <= is_mul ? 5'(MUL_LAT - 1) : 5'd31;
            rem_q <= '0;
            quo_q <= a_mag;
            dvs_q <= b_mag;
          end else if (start && !flush) begin
            if (op == ALU_MTHI) hi_q <= src_a;
            if (op == ALU_MTLO) lo_q <= src_a;
          end
        end
        MUL: begin
          if (!flush) begin
            if (cnt_q == '0) begin
              {hi_q, lo_q} <= prod;
              done_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
        end
        DIV: begin
          if (!flush) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - 5'd1;
          end
        end
        FIX: begin
          if (!flush) begin
            if (dvs_q == '0) begin
              hi_q <= a_q;
              lo_q <= '1;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Execute-stage block, directly downstream of the control decoder.
- Consumes the decoder's alu_op for MULT/MULTU/DIV/DIVU/MTHI/MTLO, together with the rs/rt operands.
- Owns the architectural HI/LO registers. Runs multi-cycle multiply (pipelined) and radix-2 iterative divide.
- Drives a stall (busy) to the pipeline control so a following MFHI/MFLO reads the finished result.

Parameters:
MUL_LAT, 2, multiply latency in cycles after acceptance; legal range 1..4.

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
flush  in  1  exception/ERET flush: abort in-flight op, suppress HI/LO write
start  in  1  EX-stage instruction valid this cycle
op  in  6  alu_op code (ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO; all other codes ignored)
src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
src_b  in  32  rt operand (divisor / multiplier)
busy  out  1  stall request, combinational
done  out  1  one-cycle pulse: new HI/LO visible this cycle
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (rst, synchronous, active-high; clock clk): hi=0, lo=0, state=IDLE, done=0. busy forced 0 while rst is high. rst takes priority over every other input.
- States: IDLE, MUL, DIV, FIX.
- Acceptance: in cycle T, state==IDLE, start=1, flush=0 and op is a mul/div op. Operands are latched at the T edge.
- busy = (state==IDLE && start && mul/div op && !flush) || state!=IDLE.
- Multiply:
  - MUL state for cycles T+1..T+MUL_LAT.
  - {hi,lo} <= full 64-bit product at the edge ending T+MUL_LAT.
  - State returns to IDLE at T+MUL_LAT+1; done=1 in that cycle.
  - busy is high T..T+MUL_LAT.
  - MULT: signed x signed. MULTU: unsigned x unsigned.
- Divide:
  - DIV state for cycles T+1..T+32, one restoring quotient bit per cycle on operand magnitudes.
  - FIX at T+33 applies sign correction and writes hi=remainder, lo=quotient.
  - IDLE with done=1 at T+34. busy is high T..T+33.
- Signed divide rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (DIV or DIVU): full normal latency, then hi=src_a, lo=0xFFFFFFFF regardless of sign.
- MTHI/MTLO:
  - Accepted only in IDLE with flush=0.
  - hi (or lo) <= src_a at the T edge; the other register is untouched.
  - busy stays 0; done is not pulsed.
- start while state!=IDLE: ignored; the pipeline guarantees this does not occur.
- flush:
  - In any state, state goes to IDLE next cycle.
  - No HI/LO write, no done pulse; busy drops the following cycle.
  - A flush in the same cycle as start blocks acceptance, including MTHI/MTLO.
  - A flush in the FIX cycle suppresses the write.
- hi/lo are read directly by MFHI/MFLO in EX. No internal bypass; the stall covers the hazard.
- done is registered and deasserts after one cycle.

Test Plan:
- Reset: rst high 2 cycles -> hi=0, lo=0, busy=0, done=0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, MUL_LAT=2 -> busy high T..T+2; hi=0xFFFFFFFE, lo=0x00000001 with done=1 at T+3.
- MULT (-2) x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV signed cases:
  - DIV -7 / 2 -> busy exactly 34 cycles (T..T+33); at T+34 lo=0xFFFFFFFD, hi=0xFFFFFFFF, done=1.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF after full latency.
- Write and abort:
  - MTHI 0x1234 then MTLO 0x5678 -> hi=0x1234, lo=0x5678, busy never asserted.
  - Then DIVU 10/3 with flush at T+10 -> busy=0 at T+11, hi/lo stay 0x1234/0x5678, no done pulse.
